iter_shift_unit: RTL and testbench

Multi-cycle, parametrised shift engine that generalises the 1-bit logical/arithmetic shift cells to WIDTH bits and a variable shift amount. It shifts one bit position per clock and accumulates a sticky sign-change overflow flag. It uses valid/ready handshakes on both sides and sits between the ALU operand registers and the result mux.

---
 rtl/iter_shift_pkg.sv | 13 +
 rtl/iter_shift_unit_step.sv | 25 ++
 rtl/iter_shift_unit.sv | 85 ++++++++
 tb/tb_iter_shift_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/iter_shift_pkg.sv
// iter_shift_pkg: shared op codes, FSM state type and shift-amount clamp for iter_shift_unit.
package iter_shift_pkg;
  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASL = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  function automatic int clamp_shamt(input int s, input int lim);
    return s > lim ? lim : s;
  endfunction
endpackage

// File: rtl/iter_shift_unit_step.sv
// shift_step: one-bit-position shift/rotate of y_in selected by op, plus MSB-change flag.
//   op         normalised op code (rotate codes only reach here when ITER_SHIFT_ROTATE_EN is defined)
//   y_in/y_out value before/after one step
//   msb_toggle y_in MSB differs from y_out MSB
module shift_step
  import iter_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] y_out,
  output logic             msb_toggle
);
  logic [WIDTH-1:0] sh;
  // op[0] picks right vs left; only ASR refills the MSB from itself
  assign sh = op[0] ? {op == OP_ASR && y_in[WIDTH-1], y_in[WIDTH-1:1]} : {y_in[WIDTH-2:0], 1'b0};
`ifdef ITER_SHIFT_ROTATE_EN
  assign y_out = op == OP_ROL ? {y_in[WIDTH-2:0], y_in[WIDTH-1]} :
                 op == OP_ROR ? {y_in[0], y_in[WIDTH-1:1]} : sh;
`else
  assign y_out = sh;
`endif
  assign msb_toggle = y_in[WIDTH-1] ^ y_out[WIDTH-1];
endmodule

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter, one bit position per clock, sticky MSB-change overflow.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake carrying op, a, shamt
//   out_valid/out_ready   result handshake carrying y, of
//   Macro ITER_SHIFT_ROTATE_EN adds ROL/ROR on op 100/101 (unclamped amount).
module iter_shift_unit
  import iter_shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               of
);
  // counter must hold both the clamped amount (WIDTH) and a full rotate amount
  localparam int CNT_W = SHAMT_W > $clog2(WIDTH + 1) ? SHAMT_W : $clog2(WIDTH + 1);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff;
  logic [2:0]       op_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] step_y;
  logic             toggle;
  logic             accept;
`ifdef ITER_SHIFT_ROTATE_EN
  // 110/111 fall back to ASL/ASR, so only 100/101 keep op[2]
  assign op_n = op[1] ? {1'b0, op[1:0]} : op;
`else
  logic unused_op;
  assign unused_op = op[2];
  assign op_n = {1'b0, op[1:0]};
`endif
  assign eff = op_n[2] ? CNT_W'(shamt) : CNT_W'(clamp_shamt(int'(shamt), WIDTH));
  assign in_ready = rst_n && (state == ST_IDLE || (state == ST_DONE && out_ready));
  assign accept = in_valid && in_ready;
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op        (op_q),
    .y_in      (y),
    .y_out     (step_y),
    .msb_toggle(toggle)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      y         <= '0;
      of        <= 1'b0;
      out_valid <= 1'b0;
      cnt       <= '0;
      op_q      <= '0;
    end else if (accept) begin
      y         <= a;
      of        <= 1'b0;
      cnt       <= eff;
      op_q      <= op_n;
      state     <= eff == '0 ? ST_DONE : ST_SHIFT;
      out_valid <= eff == '0;
    end else begin
      case (state)
        ST_SHIFT: begin
          y   <= step_y;
          of  <= of | toggle;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: scoreboard bench for iter_shift_unit with directed and random commands.
module tb_iter_shift_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [2:0]  op = 0;
  logic [15:0] a = 0;
  logic [4:0]  shamt = 0;
  logic        in_ready;
  logic        out_valid;
  logic        of;
  logic [15:0] y;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit rr_mode = 0;
  bit seen = 0;
  typedef struct {logic [15:0] y; logic of; int due; string tag;} exp_t;
  exp_t q[$];

  iter_shift_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a),
    .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .y(y), .of(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rr_mode) begin #1 out_ready = 1'($urandom_range(0, 1)); end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference: MSB after k steps is read straight from the operand; of is set iff any differs from the original MSB.
  function automatic void model(input logic [2:0] o, input logic [15:0] av, input int s,
                                output logic [15:0] ey, output logic eo, output int n);
    bit rot;
    logic [31:0] d;
    logic [31:0] t;
    logic b;
    rot = 0;
`ifdef ITER_SHIFT_ROTATE_EN
    rot = o[2] && !o[1];
`endif
    n = rot ? s : (s > 16 ? 16 : s);
    eo = 0;
    for (int k = 1; k <= n; k++) begin
      if (rot) b = o[0] ? av[(15 + k) % 16] : av[((15 - k) % 16 + 16) % 16];
      else if (o[1:0] == 2'b01) b = 0;
      else if (o[1:0] == 2'b11) b = av[15];
      else b = k <= 15 ? av[15 - k] : 1'b0;
      if (b != av[15]) eo = 1;
    end
    d = {av, av};
    if (rot && o[0]) begin
      t = d >> (s % 16);
      ey = t[15:0];
    end else if (rot) begin
      t = d << (s % 16);
      ey = t[31:16];
    end else if (o[1:0] == 2'b01) ey = av >> n;
    else if (o[1:0] == 2'b11) ey = 16'($signed(av) >>> n);
    else begin
      t = {16'b0, av} << n;
      ey = t[15:0];
    end
  endfunction

  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [15:0] av, input logic [4:0] s,
                       input logic [15:0] ey, input logic eo, input int n, input string tag, input bit push);
    int w = 0;
    op = o; a = av; shamt = s; in_valid = 1;
    do begin @(negedge clk); w++; end while (!in_ready && w < 200);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL %s accept: in_ready stuck at 0 for %0d cycles", tag, w);
      finish_up();
    end
    @(posedge clk); #1;
    if (push) q.push_back('{ey, eo, cyc + n, tag});
    in_valid = 0; op = 3'($urandom); a = 16'($urandom); shamt = 5'($urandom);
  endtask

  task automatic issue_m(input logic [2:0] o, input logic [15:0] av, input logic [4:0] s, input string tag);
    logic [15:0] ey; logic eo; int n;
    model(o, av, int'(s), ey, eo, n);
    issue(o, av, s, ey, eo, n, tag, 1);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (q.size() != 0 && w < 300) begin @(negedge clk); w++; end
    chk({tag, " drained"}, q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk({q[0].tag, " latency"}, cyc, q[0].due);
      end
      if (out_ready) begin
        if (q.size() > 0) begin
          chk({q[0].tag, " y"}, y, q[0].y);
          chk({q[0].tag, " of"}, of, q[0].of);
          void'(q.pop_front());
        end
        seen = 0;
      end
    end
  end

  initial begin
    #900000;
    total++; bad++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_up();
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst y", y, 0);
    chk("rst of", of, 0);
    chk("rst out_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1;
    issue(3'b000, 16'h4001, 5'd1,  16'h8002, 1'b1, 1,  "lsl_4001_1", 1);
    issue(3'b011, 16'h8004, 5'd2,  16'hE001, 1'b0, 2,  "asr_8004_2", 1);
    issue(3'b001, 16'h8004, 5'd2,  16'h2001, 1'b1, 2,  "lsr_8004_2", 1);
    issue(3'b001, 16'h8000, 5'd20, 16'h0000, 1'b1, 16, "lsr_8000_20", 1);
    issue(3'b011, 16'h8000, 5'd20, 16'hFFFF, 1'b0, 16, "asr_8000_20", 1);
    issue(3'b010, 16'h1234, 5'd0,  16'h1234, 1'b0, 0,  "asl_1234_0", 1);
    drain("directed");
    out_ready = 0;
    issue(3'b010, 16'h1234, 5'd0, 16'h1234, 1'b0, 0, "bp_hold", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp y stable", y, 16'h1234);
      chk("bp of stable", of, 0);
      chk("bp in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    issue(3'b000, 16'h0001, 5'd3, 16'h0008, 1'b0, 3, "b2b_lsl_1_3", 1);
    drain("backpressure");
    issue(3'b000, 16'h00FF, 5'd8, 16'h0, 1'b0, 0, "rst_mid", 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid y", y, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("rst_mid in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    chk("rst_mid no stale result", out_valid, 0);
    @(posedge clk); #1;
`ifdef ITER_SHIFT_ROTATE_EN
    issue(3'b100, 16'h8001, 5'd1,  16'h0003, 1'b1, 1,  "rol_8001_1", 1);
    issue(3'b101, 16'h0001, 5'd17, 16'h8000, 1'b1, 17, "ror_0001_17", 1);
    drain("rotate");
`endif
    rr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [4:0] s;
      s = $urandom_range(0, 3) == 0 ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 17));
      issue_m(3'($urandom_range(0, 7)), 16'($urandom), s, $sformatf("rnd%0d", i));
    end
    rr_mode = 0;
    @(negedge clk) out_ready = 1;
    drain("random");
    finish_up();
  end
endmodule
